// File: rtl/segasys1_vtim_pkg.sv
// Shared timing constants and types for the System 1 raster timing generator.
// The default geometry is 384x264 total, with 256x224 visible.
package segasys1_vtim_pkg;

  localparam int COORD_W = 9;
  localparam int START_W = 10;
  localparam int OFFS_W  = 4;

  localparam int unsigned H_TOTAL_D  = 384;
  localparam int unsigned H_ACTIVE_D = 256;
  localparam int unsigned HS_START_D = 296;
  localparam int unsigned HS_WIDTH_D = 32;
  localparam int unsigned V_TOTAL_D  = 264;
  localparam int unsigned V_ACTIVE_D = 224;
  localparam int unsigned VS_START_D = 240;
  localparam int unsigned VS_WIDTH_D = 3;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [START_W-1:0] start_t;
  typedef logic signed [OFFS_W-1:0]  offs_t;

  // A nominal sync start shifted by a signed offset. Ten signed bits hold
  // every legal result, so the sum cannot wrap.
  function automatic start_t sync_start(input int unsigned nominal, input offs_t offs);
    return start_t'(nominal) + start_t'(offs);
  endfunction

endpackage

// File: rtl/segasys1_sync_window.sv
// Registered window comparator: the flag is set when count lies in
// [start, start + width). The count fed in is the next counter value, so
// the flag lines up with the counter register it was decoded from.
module segasys1_sync_window
  import segasys1_vtim_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  coord_t count,
  input  start_t start,
  input  coord_t width,
  output logic   flag
);

  logic signed [START_W+1:0] cnt_s;
  logic signed [START_W+1:0] lo_s;
  logic signed [START_W+1:0] hi_s;
  logic                      hit;

  // Compare in a widened signed domain so start + width never overflows.
  always_comb begin
    cnt_s = signed'({3'b000, count});
    lo_s  = (START_W+2)'(start);
    hi_s  = lo_s + signed'({3'b000, width});
    hit   = (cnt_s >= lo_s) && (cnt_s < hi_s);
  end

  // The flag updates only on pixel-enable cycles and clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (en) begin
      flag <= hit;
    end
  end

endmodule

// File: rtl/segasys1_vtiming.sv
// System 1 raster timing generator. It advances PH/PV on each PCLK_EN cycle
// and produces registered blanking, DE, sync and frame-start flags. These
// flags are decoded from the next counter values, so they change together
// with PH/PV.
// Optional feature, SEGASYS1_VTIM_OFFSET_EN: HOFFS/VOFFS are latched at each
// frame wrap and shift the HSYNC/VSYNC windows. When the macro is undefined,
// both sync windows sit at their nominal positions.
module segasys1_vtiming
  import segasys1_vtim_pkg::*;
#(
  parameter int unsigned H_TOTAL  = H_TOTAL_D,
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned HS_START = HS_START_D,
  parameter int unsigned HS_WIDTH = HS_WIDTH_D,
  parameter int unsigned V_TOTAL  = V_TOTAL_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned VS_START = VS_START_D,
  parameter int unsigned VS_WIDTH = VS_WIDTH_D
)
(
  input  logic               clk48M,
  input  logic               reset,
  input  logic               PCLK_EN,
  input  logic [OFFS_W-1:0]  HOFFS,
  input  logic [OFFS_W-1:0]  VOFFS,
  output logic [COORD_W-1:0] PH,
  output logic [COORD_W-1:0] PV,
  output logic               HBLANK,
  output logic               VBLANK,
  output logic               DE,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               FRAME_START
);

  // Reject geometries where some offset would push sync out of blanking,
  // or where a counter would not fit in the coordinate width.
  if (HS_START < H_ACTIVE + 8 || HS_START + 7 + HS_WIDTH > H_TOTAL) begin : g_hs_chk
    $error("HSYNC window can leave horizontal blanking");
  end
  if (VS_START < V_ACTIVE + 8 || VS_START + 7 + VS_WIDTH > V_TOTAL) begin : g_vs_chk
    $error("VSYNC window can leave vertical blanking");
  end
  if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_w_chk
    $error("Timing totals exceed coordinate width");
  end

  coord_t ph_p0;
  coord_t pv_p0;
  logic   line_adv;
  logic   frame_wrap;
  logic   hb_p0;
  logic   vb_p0;
  start_t hs0;
  start_t vs0;

  // Next-count logic: PH wraps at line end, and PV advances at line end.
  always_comb begin
    line_adv   = (PH == coord_t'(H_TOTAL - 1));
    frame_wrap = line_adv && (PV == coord_t'(V_TOTAL - 1));
    ph_p0      = line_adv ? '0 : PH + 1'b1;
    pv_p0      = PV;
    if (line_adv) begin
      pv_p0 = frame_wrap ? '0 : PV + 1'b1;
    end
    hb_p0 = (ph_p0 >= coord_t'(H_ACTIVE));
    vb_p0 = (pv_p0 >= coord_t'(V_ACTIVE));
  end

`ifdef SEGASYS1_VTIM_OFFSET_EN
  offs_t hoffs_q;
  offs_t voffs_q;

  // Offsets take effect only at frame boundaries, so a frame never tears.
  always_ff @(posedge clk48M) begin
    if (reset) begin
      hoffs_q <= '0;
      voffs_q <= '0;
    end else if (PCLK_EN && frame_wrap) begin
      hoffs_q <= offs_t'(HOFFS);
      voffs_q <= offs_t'(VOFFS);
    end
  end

  assign hs0 = sync_start(HS_START, hoffs_q);
  assign vs0 = sync_start(VS_START, voffs_q);
`else
  logic unused_offs;
  assign unused_offs = ^{HOFFS, VOFFS};
  assign hs0 = sync_start(HS_START, '0);
  assign vs0 = sync_start(VS_START, '0);
`endif

  // Counter, blanking, DE and frame-start registers.
  always_ff @(posedge clk48M) begin
    if (reset) begin
      PH          <= '0;
      PV          <= '0;
      HBLANK      <= 1'b0;
      VBLANK      <= 1'b0;
      DE          <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= PCLK_EN && frame_wrap;
      if (PCLK_EN) begin
        PH     <= ph_p0;
        PV     <= pv_p0;
        HBLANK <= hb_p0;
        VBLANK <= vb_p0;
        DE     <= ~hb_p0 & ~vb_p0;
      end
    end
  end

  segasys1_sync_window u_hsync (
    .clk   (clk48M),
    .rst   (reset),
    .en    (PCLK_EN),
    .count (ph_p0),
    .start (hs0),
    .width (coord_t'(HS_WIDTH)),
    .flag  (HSYNC)
  );

  // pv_p0 moves only at line advance, so VSYNC can change only when PH returns to 0.
  segasys1_sync_window u_vsync (
    .clk   (clk48M),
    .rst   (reset),
    .en    (PCLK_EN),
    .count (pv_p0),
    .start (vs0),
    .width (coord_t'(VS_WIDTH)),
    .flag  (VSYNC)
  );

endmodule

// File: tb/tb_segasys1_vtiming.sv
// Directed bench for segasys1_vtiming. The vertical geometry is shortened to
// 40 lines (16 active, VSYNC nominal at 26..28), which keeps whole-frame
// scenarios within a short run. The horizontal geometry keeps its defaults.
module tb_segasys1_vtiming;

  localparam int V_T  = 40;
  localparam int V_A  = 16;
  localparam int VS_S = 26;
  localparam int VS_W = 3;

  logic       clk48M = 1'b0;
  logic       reset = 1'b1;
  logic       PCLK_EN = 1'b0;
  logic [3:0] HOFFS = 4'd0;
  logic [3:0] VOFFS = 4'd0;
  logic [8:0] PH, PV;
  logic       HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START;

  int checks = 0;
  int errors = 0;
  int mph = 0;
  int mpv = 0;
  bit mwrap = 1'b0;

  segasys1_vtiming #(
    .V_TOTAL (V_T),
    .V_ACTIVE(V_A),
    .VS_START(VS_S),
    .VS_WIDTH(VS_W)
  ) dut (
    .clk48M     (clk48M),
    .reset      (reset),
    .PCLK_EN    (PCLK_EN),
    .HOFFS      (HOFFS),
    .VOFFS      (VOFFS),
    .PH         (PH),
    .PV         (PV),
    .HBLANK     (HBLANK),
    .VBLANK     (VBLANK),
    .DE         (DE),
    .HSYNC      (HSYNC),
    .VSYNC      (VSYNC),
    .FRAME_START(FRAME_START)
  );

  always #10 clk48M = ~clk48M;

  // Output vector: {PH, PV, HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START}.
  function automatic logic [23:0] expv(int ph, int pv, int hs_lo, int vs_lo, bit fs);
    logic hb, vb;
    hb = (ph >= 256);
    vb = (pv >= V_A);
    return {9'(ph), 9'(pv), hb, vb, ~hb & ~vb,
            (ph >= hs_lo) && (ph < hs_lo + 32),
            (pv >= vs_lo) && (pv < vs_lo + VS_W), fs};
  endfunction

  task automatic tick(input logic en);
    PCLK_EN = en;
    @(posedge clk48M);
    #1;
  endtask

  task automatic pulse();
    tick(1'b1);
    mwrap = 1'b0;
    if (mph == 383) begin
      mph = 0;
      if (mpv == V_T - 1) begin
        mpv = 0;
        mwrap = 1'b1;
      end else begin
        mpv++;
      end
    end else begin
      mph++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    mph = 0;
    mpv = 0;
    mwrap = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    obs = {PH, PV, HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START};
    checks++;
    if (obs !== expv(0, 0, 296, VS_S, 1'b0)) begin
      errors++;
      $display("FAIL reset_initial: got %h expected %h", obs, expv(0, 0, 296, VS_S, 1'b0));
    end
    reset = 1'b0;
    mph = 0;
    mpv = 0;
    repeat (20 * 384 + 100) pulse();
    checks++;
    if (PH !== 9'd100 || PV !== 9'd20) begin
      errors++;
      $display("FAIL reset_prepos: got PH=%0d PV=%0d expected PH=100 PV=20", PH, PV);
    end
    reset = 1'b1;
    tick(1'b1);
    obs = {PH, PV, HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START};
    checks++;
    if (obs !== expv(0, 0, 296, VS_S, 1'b0)) begin
      errors++;
      $display("FAIL reset_midframe: got %h expected %h", obs, expv(0, 0, 296, VS_S, 1'b0));
    end
    reset = 1'b0;
    mph = 0;
    mpv = 0;
    tick(1'b0);
    checks++;
    if (PH !== 9'd0 || PV !== 9'd0 || DE !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got PH=%0d PV=%0d DE=%b expected 0 0 1", PH, PV, DE);
    end
  endtask

  task automatic test_line();
    logic [23:0] obs;
    for (int i = 0; i < 384; i++) begin
      repeat (7) tick(1'b0);
      pulse();
      obs = {PH, PV, HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START};
      checks++;
      if (obs !== expv(mph, mpv, 296, VS_S, 1'b0)) begin
        errors++;
        $display("FAIL line_step%0d: got %h expected %h", i, obs, expv(mph, mpv, 296, VS_S, 1'b0));
      end
    end
    checks++;
    if (PH !== 9'd0 || PV !== 9'd1) begin
      errors++;
      $display("FAIL line_end: got PH=%0d PV=%0d expected PH=0 PV=1", PH, PV);
    end
  endtask

  task automatic test_frame();
    logic [23:0] obs;
    int fs_cnt;
    do_reset();
    fs_cnt = 0;
    for (int i = 0; i < 384 * V_T; i++) begin
      pulse();
      if (FRAME_START === 1'b1) fs_cnt++;
      obs = {PH, PV, HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START};
      checks++;
      if (obs !== expv(mph, mpv, 296, VS_S, mwrap)) begin
        errors++;
        $display("FAIL frame_step%0d: got %h expected %h", i, obs, expv(mph, mpv, 296, VS_S, mwrap));
      end
    end
    checks++;
    if (fs_cnt != 1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
    end
    tick(1'b0);
    checks++;
    if (FRAME_START !== 1'b0 || PH !== 9'd0 || PV !== 9'd0) begin
      errors++;
      $display("FAIL frame_start_width: got FS=%b PH=%0d PV=%0d expected 0 0 0", FRAME_START, PH, PV);
    end
  endtask

  task automatic test_offset();
    logic [23:0] obs;
    int hs_lo, vs_lo;
`ifdef SEGASYS1_VTIM_OFFSET_EN
    logic [3:0] h_new = 4'b1101;
    logic [3:0] v_new = 4'd2;
    hs_lo = 293;
    vs_lo = VS_S + 2;
`else
    logic [3:0] h_new = 4'd7;
    logic [3:0] v_new = 4'b1000;
    hs_lo = 296;
    vs_lo = VS_S;
`endif
    for (int i = 0; i < 384 * V_T; i++) begin
      if (mpv == 10 && mph == 0) begin
        HOFFS = h_new;
        VOFFS = v_new;
      end
      pulse();
      obs = {PH, PV, HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START};
      checks++;
      if (obs !== expv(mph, mpv, 296, VS_S, mwrap)) begin
        errors++;
        $display("FAIL offs_cur%0d: got %h expected %h", i, obs, expv(mph, mpv, 296, VS_S, mwrap));
      end
    end
    for (int i = 0; i < 384 * V_T; i++) begin
      pulse();
      obs = {PH, PV, HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START};
      checks++;
      if (obs !== expv(mph, mpv, hs_lo, vs_lo, mwrap)) begin
        errors++;
        $display("FAIL offs_next%0d: got %h expected %h", i, obs, expv(mph, mpv, hs_lo, vs_lo, mwrap));
      end
    end
    HOFFS = 4'd0;
    VOFFS = 4'd0;
  endtask

  task automatic test_freeze();
    logic [23:0] obs;
    do_reset();
    repeat (255) pulse();
    obs = {PH, PV, HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START};
    checks++;
    if (obs !== expv(255, 0, 296, VS_S, 1'b0)) begin
      errors++;
      $display("FAIL freeze_pre: got %h expected %h", obs, expv(255, 0, 296, VS_S, 1'b0));
    end
    for (int i = 0; i < 50; i++) begin
      tick(1'b0);
      obs = {PH, PV, HBLANK, VBLANK, DE, HSYNC, VSYNC, FRAME_START};
      checks++;
      if (obs !== expv(255, 0, 296, VS_S, 1'b0)) begin
        errors++;
        $display("FAIL freeze_hold%0d: got %h expected %h", i, obs, expv(255, 0, 296, VS_S, 1'b0));
      end
    end
    pulse();
    checks++;
    if (PH !== 9'd256 || HBLANK !== 1'b1 || DE !== 1'b0) begin
      errors++;
      $display("FAIL freeze_resume: got PH=%0d HBLANK=%b DE=%b expected 256 1 0", PH, HBLANK, DE);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_offset();
    test_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
